conv_frame_loader: RTL

Upstream input stage for the convolution layer. Assembles a ROWS x COLS binary image from switch inputs, one row per strobe, and presents the complete frame on a 36-bit bus with a valid/ready handshake. Switch inputs are asynchronous, so it synchronises and edge-detects them. Sits between the top-level pin map (ui_in[5:0] row bits, ui_in[6] row strobe, ui_in[7] frame load) and the convolution layer's data input.

---
 rtl/conv_frame_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/conv_frame_loader.sv
// Row-by-row binary frame assembler with switch synchronisers and valid/ready output.
// Optional debouncer on the strobe/load switches: define DEBOUNCE_EN.
module conv_frame_loader #(
  parameter int unsigned ROWS            = 6,
  parameter int unsigned COLS            = 6,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COLS-1:0]      row_data,
  input  logic                 row_strobe,
  input  logic                 frame_load,
  input  logic                 clear,
  output logic [ROWS*COLS-1:0] frame_data,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [2:0]           row_count,
  output logic                 overflow
);

  localparam logic [1:0] S_FILL    = 2'd0;
  localparam logic [1:0] S_FULL    = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [2:0] LAST_ROW  = 3'(ROWS - 1);

  logic [SYNC_STAGES-1:0] strobe_sync, load_sync;
  logic [COLS-1:0]        data_sync [SYNC_STAGES];
  logic                   strobe_lvl, load_lvl;
  logic                   strobe_prev, load_prev;
  logic                   strobe_edge, load_edge;
  logic [1:0]             state;
  logic [COLS-1:0]        rows [ROWS];
  logic [ROWS*COLS-1:0]   rows_flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_sync <= '0;
      load_sync   <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
    end else begin
      strobe_sync  <= {strobe_sync[SYNC_STAGES-2:0], row_strobe};
      load_sync    <= {load_sync[SYNC_STAGES-2:0], frame_load};
      data_sync[0] <= row_data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      raw, filt;
  logic [DB_W-1:0] db_cnt [2];

  assign raw = {load_sync[SYNC_STAGES-1], strobe_sync[SYNC_STAGES-1]};

  // Filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= raw[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign strobe_lvl = filt[0];
  assign load_lvl   = filt[1];
`else
  assign strobe_lvl = strobe_sync[SYNC_STAGES-1];
  assign load_lvl   = load_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_prev <= 1'b0;
      load_prev   <= 1'b0;
    end else begin
      strobe_prev <= strobe_lvl;
      load_prev   <= load_lvl;
    end
  end

  assign strobe_edge = strobe_lvl & ~strobe_prev;
  assign load_edge   = load_lvl & ~load_prev;

  always_comb begin
    rows_flat = '0;
    for (int unsigned r = 0; r < ROWS; r++) rows_flat[r*COLS +: COLS] = rows[r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FILL;
      row_count   <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
      for (int unsigned r = 0; r < ROWS; r++) rows[r] <= '0;
    end else if (clear) begin
      state       <= S_FILL;
      row_count   <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
      for (int unsigned r = 0; r < ROWS; r++) rows[r] <= '0;
    end else begin
      case (state)
        S_FILL: begin
          // A load edge here is dropped, even when coincident with the final row.
          if (strobe_edge) begin
            for (int unsigned r = 0; r < ROWS; r++)
              if (row_count == 3'(r)) rows[r] <= data_sync[SYNC_STAGES-1];
            row_count <= row_count + 3'd1;
            if (row_count == LAST_ROW) state <= S_FULL;
          end
        end
        S_FULL: begin
          if (strobe_edge) overflow <= 1'b1;
          if (load_edge) begin
            frame_data  <= rows_flat;
            frame_valid <= 1'b1;
            state       <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (strobe_edge) overflow <= 1'b1;
          if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
            row_count   <= '0;
            state       <= S_FILL;
            for (int unsigned r = 0; r < ROWS; r++) rows[r] <= '0;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule
